mshr_producer_unit: RTL and testbench

MSHR_PRODUCER_UNIT -- requirements
Module: mshr_producer_unit

---
 rtl/mshr_producer_unit.sv | 127 ++++++++++++
 tb/tb_mshr_producer_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mshr_producer_unit.sv
// rtl/mshr_producer_unit.sv - splits a 128-bit cacheline store into two 64-bit NoC2 beats and tracks their acks
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   trans_valid/ready/addr/data store request (one cacheline per transaction)
//   done_valid/ready            completion handshake, raised once both beats are acked
//   st_valid/ready/addr/data/size/mshrid  store-beat stream toward the NoC2 adapter
//   ack_valid, ack_mshrid       store-ack pulses from the NoC3 adapter
//   err_align/err_ack/err_timeout sticky error flags, cleared only by reset
module mshr_producer_unit #(
    parameter int          ADDR_W    = 40,
    parameter logic [7:0]  MSHRID_LO = 8'd149,
    parameter logic [7:0]  MSHRID_HI = 8'd150,
    parameter logic [15:0] TIMEOUT   = 16'd4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trans_valid,
    output logic              trans_ready,
    input  logic [ADDR_W-1:0] trans_addr,
    input  logic [127:0]      trans_data,
    output logic              done_valid,
    input  logic              done_ready,
    output logic              st_valid,
    input  logic              st_ready,
    output logic [ADDR_W-1:0] st_addr,
    output logic [63:0]       st_data,
    output logic [2:0]        st_size,
    output logic [7:0]        st_mshrid,
    input  logic              ack_valid,
    input  logic [7:0]        ack_mshrid,
    output logic              err_align,
    output logic              err_ack,
    output logic              err_timeout
);

    typedef enum logic [2:0] {S_IDLE, S_BEAT0, S_BEAT1, S_WAIT, S_DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [127:0]      data_q;
    logic              ack_lo;
    logic              ack_hi;
    logic [15:0]       wait_cnt;

    logic in_beat0, in_beat1, in_wait;
    logic lo_issued, hi_issued;
    logic ack_set_lo, ack_set_hi, ack_bad;

    assign in_beat0 = (state == S_BEAT0);
    assign in_beat1 = (state == S_BEAT1);
    assign in_wait  = (state == S_WAIT);

    // A beat counts as issued from the cycle of its handshake onward, so an
    // ack that lands together with the handshake is still legal.
    assign lo_issued = (in_beat0 && st_ready) || in_beat1 || in_wait;
    assign hi_issued = (in_beat1 && st_ready) || in_wait;

    assign ack_set_lo = ack_valid && (ack_mshrid == MSHRID_LO) && lo_issued && !ack_lo;
    assign ack_set_hi = ack_valid && (ack_mshrid == MSHRID_HI) && hi_issued && !ack_hi;
    // Anything else (unknown tag, early, duplicate, idle/done) is only flagged.
    assign ack_bad    = ack_valid && !ack_set_lo && !ack_set_hi;

    // Beat fields are decoded from the state and captured line, so they are
    // inherently stable while the sink stalls.
    assign trans_ready = rst_n && (state == S_IDLE);
    assign st_valid    = in_beat0 || in_beat1;
    assign st_addr     = in_beat0 ? addr_q : (in_beat1 ? addr_q + ADDR_W'(8) : '0);
    assign st_data     = in_beat0 ? data_q[63:0] : (in_beat1 ? data_q[127:64] : 64'd0);
    assign st_size     = st_valid ? 3'b011 : 3'b000;
    assign st_mshrid   = in_beat0 ? MSHRID_LO : (in_beat1 ? MSHRID_HI : 8'd0);
    assign done_valid  = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            ack_lo      <= 1'b0;
            ack_hi      <= 1'b0;
            wait_cnt    <= 16'd0;
            err_align   <= 1'b0;
            err_ack     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (ack_set_lo) ack_lo  <= 1'b1;
            if (ack_set_hi) ack_hi  <= 1'b1;
            if (ack_bad)    err_ack <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (trans_valid) begin
                        addr_q <= {trans_addr[ADDR_W-1:4], 4'b0000};
                        data_q <= trans_data;
                        ack_lo <= 1'b0;
                        ack_hi <= 1'b0;
                        if (trans_addr[3:0] != 4'd0) err_align <= 1'b1;
                        state  <= S_BEAT0;
                    end
                end
                S_BEAT0: begin
                    if (st_ready) state <= S_BEAT1;
                end
                S_BEAT1: begin
                    if (st_ready) begin
                        wait_cnt <= 16'd0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Timeout only flags; late acks can still complete.
                    if (ack_lo && ack_hi) begin
                        state <= S_DONE;
                    end else if (wait_cnt != TIMEOUT) begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (wait_cnt == TIMEOUT - 16'd1) err_timeout <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (done_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mshr_producer_unit.sv
// tb/tb_mshr_producer_unit.sv - directed self-checking bench for mshr_producer_unit
module tb_mshr_producer_unit;

    localparam int ADDR_W = 40;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              trans_valid = 1'b0;
    logic              trans_ready;
    logic [ADDR_W-1:0] trans_addr = '0;
    logic [127:0]      trans_data = '0;
    logic              done_valid;
    logic              done_ready = 1'b0;
    logic              st_valid;
    logic              st_ready = 1'b0;
    logic [ADDR_W-1:0] st_addr;
    logic [63:0]       st_data;
    logic [2:0]        st_size;
    logic [7:0]        st_mshrid;
    logic              ack_valid = 1'b0;
    logic [7:0]        ack_mshrid = 8'd0;
    logic              err_align;
    logic              err_ack;
    logic              err_timeout;

    int errors = 0;
    int checks = 0;

    mshr_producer_unit #(.ADDR_W(ADDR_W), .TIMEOUT(16'd16)) dut (
        .clk(clk), .rst_n(rst_n),
        .trans_valid(trans_valid), .trans_ready(trans_ready),
        .trans_addr(trans_addr), .trans_data(trans_data),
        .done_valid(done_valid), .done_ready(done_ready),
        .st_valid(st_valid), .st_ready(st_ready),
        .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .st_mshrid(st_mshrid),
        .ack_valid(ack_valid), .ack_mshrid(ack_mshrid),
        .err_align(err_align), .err_ack(err_ack), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [ADDR_W-1:0] a, input logic [127:0] d);
        trans_valid = 1'b1;
        trans_addr  = a;
        trans_data  = d;
        tick();
        trans_valid = 1'b0;
    endtask

    task automatic send_ack(input logic [7:0] id);
        ack_valid  = 1'b1;
        ack_mshrid = id;
        tick();
        ack_valid  = 1'b0;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic finish_done;
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        checks++;
        if ({trans_ready, st_valid, done_valid, st_addr, st_data, st_size, st_mshrid} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%0b stv=%0b dv=%0b addr=%h data=%h size=%0d id=%0d expected all 0",
                     trans_ready, st_valid, done_valid, st_addr, st_data, st_size, st_mshrid);
        end
        checks++;
        if ({err_align, err_ack, err_timeout} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %b expected 000", {err_align, err_ack, err_timeout});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (trans_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after got %0b expected 1", trans_ready);
        end
    endtask

    task automatic test_basic;
        st_ready = 1'b1;
        accept(40'h100, {64'hB, 64'hA});
        checks++;
        if ({st_valid, st_addr, st_data, st_size, st_mshrid} !== {1'b1, 40'h100, 64'hA, 3'b011, 8'd149}) begin
            errors++;
            $display("FAIL basic_beat0 got v=%0b a=%h d=%h s=%0d id=%0d expected 1/100/a/3/149",
                     st_valid, st_addr, st_data, st_size, st_mshrid);
        end
        tick();
        checks++;
        if ({st_valid, st_addr, st_data, st_size, st_mshrid} !== {1'b1, 40'h108, 64'hB, 3'b011, 8'd150}) begin
            errors++;
            $display("FAIL basic_beat1 got v=%0b a=%h d=%h s=%0d id=%0d expected 1/108/b/3/150",
                     st_valid, st_addr, st_data, st_size, st_mshrid);
        end
        send_ack(8'd149);
        checks++;
        if ({st_valid, st_addr, done_valid} !== {1'b0, 40'h0, 1'b0}) begin
            errors++;
            $display("FAIL basic_wait got stv=%0b a=%h dv=%0b expected 0/0/0", st_valid, st_addr, done_valid);
        end
        send_ack(8'd150);
        checks++;
        if (done_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_early got %0b expected 0", done_valid);
        end
        tick();
        checks++;
        if ({done_valid, err_ack} !== 2'b10) begin
            errors++;
            $display("FAIL basic_done_latency got dv=%0b err_ack=%0b expected 1/0", done_valid, err_ack);
        end
        finish_done();
        checks++;
        if ({done_valid, trans_ready} !== 2'b01) begin
            errors++;
            $display("FAIL basic_return_idle got dv=%0b rdy=%0b expected 0/1", done_valid, trans_ready);
        end
    endtask

    task automatic test_backpressure;
        st_ready = 1'b0;
        accept(40'h200, {64'hD, 64'hC});
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({st_valid, st_addr, st_data, st_mshrid} !== {1'b1, 40'h200, 64'hC, 8'd149}) begin
                errors++;
                $display("FAIL bp_hold[%0d] got v=%0b a=%h d=%h id=%0d expected 1/200/c/149",
                         i, st_valid, st_addr, st_data, st_mshrid);
            end
        end
        st_ready = 1'b1;
        tick();
        checks++;
        if ({st_valid, st_addr, st_data, st_mshrid} !== {1'b1, 40'h208, 64'hD, 8'd150}) begin
            errors++;
            $display("FAIL bp_beat1 got v=%0b a=%h d=%h id=%0d expected 1/208/d/150",
                     st_valid, st_addr, st_data, st_mshrid);
        end
        send_ack(8'd149);
        send_ack(8'd150);
        tick();
        checks++;
        if (done_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_done got %0b expected 1", done_valid);
        end
        finish_done();
    endtask

    task automatic test_reorder;
        st_ready = 1'b1;
        accept(40'h300, {64'h2, 64'h1});
        tick();
        send_ack(8'd149);
        send_ack(8'd150);
        tick();
        checks++;
        if ({done_valid, err_ack} !== 2'b10) begin
            errors++;
            $display("FAIL reorder_early_lo got dv=%0b err_ack=%0b expected 1/0", done_valid, err_ack);
        end
        finish_done();
        // Beat 1 stalled; beat 0 acked meanwhile, beat 1 acked on its handshake.
        accept(40'h380, {64'h4, 64'h3});
        st_ready = 1'b0;
        tick();
        tick();
        st_ready = 1'b1;
        tick();
        st_ready = 1'b0;
        send_ack(8'd149);
        st_ready = 1'b1;
        send_ack(8'd150);
        checks++;
        if ({st_valid, done_valid} !== 2'b00) begin
            errors++;
            $display("FAIL same_cycle_wait got stv=%0b dv=%0b expected 0/0", st_valid, done_valid);
        end
        tick();
        checks++;
        if ({done_valid, err_ack} !== 2'b10) begin
            errors++;
            $display("FAIL same_cycle_done got dv=%0b err_ack=%0b expected 1/0", done_valid, err_ack);
        end
        finish_done();
    endtask

    task automatic test_errors;
        st_ready = 1'b0;
        accept(40'h104, {64'hF, 64'hE});
        checks++;
        if ({err_align, err_ack, st_addr} !== {2'b10, 40'h100}) begin
            errors++;
            $display("FAIL err_align got align=%0b ack=%0b a=%h expected 1/0/100", err_align, err_ack, st_addr);
        end
        send_ack(8'd7);
        checks++;
        if ({err_ack, st_valid, st_mshrid} !== {2'b11, 8'd149}) begin
            errors++;
            $display("FAIL err_ack_unknown got ack=%0b stv=%0b id=%0d expected 1/1/149", err_ack, st_valid, st_mshrid);
        end
        st_ready = 1'b1;
        tick();
        checks++;
        if (st_addr !== 40'h108) begin
            errors++;
            $display("FAIL err_align_beat1 got %h expected 108", st_addr);
        end
        send_ack(8'd149);
        send_ack(8'd150);
        tick();
        checks++;
        if (done_valid !== 1'b1) begin
            errors++;
            $display("FAIL err_completion got %0b expected 1", done_valid);
        end
        finish_done();

        apply_reset();
        accept(40'h140, {64'h6, 64'h5});
        tick();
        send_ack(8'd149);
        checks++;
        if (err_ack !== 1'b0) begin
            errors++;
            $display("FAIL dup_before got %0b expected 0", err_ack);
        end
        send_ack(8'd149);
        checks++;
        if (err_ack !== 1'b1) begin
            errors++;
            $display("FAIL dup_ack got %0b expected 1", err_ack);
        end
        send_ack(8'd150);
        tick();
        checks++;
        if (done_valid !== 1'b1) begin
            errors++;
            $display("FAIL dup_completion got %0b expected 1", done_valid);
        end
        finish_done();

        apply_reset();
        send_ack(8'd149);
        checks++;
        if ({err_ack, trans_ready} !== 2'b11) begin
            errors++;
            $display("FAIL idle_ack got ack=%0b rdy=%0b expected 1/1", err_ack, trans_ready);
        end
        apply_reset();
    endtask

    task automatic test_timeout;
        st_ready = 1'b1;
        accept(40'h400, {64'h8, 64'h7});
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (err_timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early got %0b expected 0", err_timeout);
        end
        tick();
        checks++;
        if ({err_timeout, done_valid, trans_ready} !== 3'b100) begin
            errors++;
            $display("FAIL timeout_set got to=%0b dv=%0b rdy=%0b expected 1/0/0", err_timeout, done_valid, trans_ready);
        end
        for (int i = 0; i < 4; i++) tick();
        send_ack(8'd150);
        send_ack(8'd149);
        tick();
        checks++;
        if ({done_valid, err_ack, err_timeout} !== 3'b101) begin
            errors++;
            $display("FAIL timeout_late_done got dv=%0b ack=%0b to=%0b expected 1/0/1", done_valid, err_ack, err_timeout);
        end
        finish_done();
    endtask

    task automatic test_reset_mid;
        st_ready = 1'b1;
        accept(40'h504, {64'h10, 64'h0F});
        tick();
        tick();
        send_ack(8'd149);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({trans_ready, done_valid, st_valid, err_align, err_ack, err_timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid got rdy=%0b dv=%0b stv=%0b flags=%b expected all 0",
                     trans_ready, done_valid, st_valid, {err_align, err_ack, err_timeout});
        end
        tick();
        rst_n = 1'b1;
        accept(40'h600, {64'h22, 64'h11});
        checks++;
        if ({st_valid, st_addr, st_data} !== {1'b1, 40'h600, 64'h11}) begin
            errors++;
            $display("FAIL reset_next_beat0 got v=%0b a=%h d=%h expected 1/600/11", st_valid, st_addr, st_data);
        end
        tick();
        send_ack(8'd149);
        send_ack(8'd150);
        tick();
        checks++;
        if ({done_valid, err_align, err_ack, err_timeout} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_next_done got dv=%0b flags=%b expected 1/000", done_valid, {err_align, err_ack, err_timeout});
        end
        finish_done();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reorder();
        test_errors();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
